// File: rtl/svc_uart_rx_mon.sv
// UART 8N1 receive monitor: 2-flop synchronizer, mid-bit sampling FSM, and a show-ahead byte FIFO.
// Latency: a byte reaches urx_valid/urx_data one cycle after its stop-bit sample; the FIFO has no read latency.
// Backpressure: urx_ready pops the head byte. If the FIFO is full and nothing pops, a completed byte is dropped and overrun pulses.
// Optional feature: define SVC_UART_RX_MON_EOT_EN to build the sticky end-of-transmission (0x04) detector.

module svc_uart_rx_mon #(
  parameter int CLOCK_FREQ_MHZ = 25,
  parameter int BAUD_RATE      = 115_200,
  parameter int FIFO_DEPTH     = 8        // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       eot
);

  // Bit timing derived from the clock and baud rate (217 / 108 at the defaults).
  localparam int CLKS_PER_BIT = (CLOCK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);

  // The counter starts at 0, so a count of N clocks ends when the counter holds N-1.
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  // Receiver states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic urx_m;
  logic urx_s;

  // Two flops remove metastability; they reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urx_m <= 1'b1;
      urx_s <= 1'b1;
    end else begin
      urx_m <= urx;
      urx_s <= urx_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic half_done;
  logic bit_done;
  logic stop_sample;
  logic push;
  logic bad_stop;

  assign half_done   = (cnt == HALF_LAST);
  assign bit_done    = (cnt == FULL_LAST);
  assign stop_sample = (state == ST_STOP) && bit_done;
  assign push        = stop_sample && urx_s;
  assign bad_stop    = stop_sample && !urx_s;

  // Start detect, mid-bit sampling of the start bit, 8 data bits LSB first, and the stop bit.
  // After a bad stop bit, BREAK waits for the line to return high before a new start can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!urx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (half_done) begin
            cnt   <= '0;
            // A start bit that is gone by mid-bit is a glitch: drop it silently.
            state <= urx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shreg   <= {urx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= urx_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (urx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        drop;

  // The extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && urx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Storage carries no reset: an empty FIFO masks the head byte on the output.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  // Pointers wrap naturally modulo FIFO_DEPTH in the index bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign urx_valid = !empty;
  assign urx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Status pulses
  // ---------------------------------------------------------------------------
  // Register the single-cycle error strobes so that both outputs come from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop;
    end
  end

`ifdef SVC_UART_RX_MON_EOT_EN
  logic eot_q;

  // Sticky until reset once an accepted byte equals 0x04. The byte itself is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eot_q <= 1'b0;
    end else if (wr_en && (shreg == 8'h04)) begin
      eot_q <= 1'b1;
    end
  end

  assign eot = eot_q;
`else
  assign eot = 1'b0;
`endif

endmodule

// File: tb/tb_svc_uart_rx_mon.sv
`timescale 1ns/1ps
// Self-checking bench for svc_uart_rx_mon at default parameters.
// A monitor collects delivered bytes and pulse counts, and the tasks compare them against expected values.
// Expected values come from byte-level rules: what was sent, FIFO capacity, and the sticky EOT.

module tb_svc_uart_rx_mon;

  localparam int CPB  = (25 * 1_000_000) / 115_200;  // 217
  localparam int HALF = CPB / 2;                     // 108

  logic       clk;
  logic       rst_n;
  logic       urx;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready;
  logic       frame_err;
  logic       overrun;
  logic       eot;

  int tests;
  int fails;

  logic [7:0] rx_q[$];
  int         fe_cnt;
  int         ov_cnt;
  logic       eot_exp;
  logic       rand_ready_en;

  int   lat_g;
  logic eot_at;
  logic eot_prev;

  svc_uart_rx_mon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .urx       (urx),
    .urx_valid (urx_valid),
    .urx_data  (urx_data),
    .urx_ready (urx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .eot       (eot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: capture accepted bytes and pulses on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (urx_valid && urx_ready) rx_q.push_back(urx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // Optional random consumer backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_ready_en) urx_ready = 1'($urandom_range(0, 1));
  end

  // Watchdog.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time expired, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  // Send one 8N1 frame. The stop-bit loop records when urx_valid first rises, and eot around that edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [8:0] frame;
    logic       v_prev;
    logic       e_prev;
    frame = {b, 1'b0};
    lat_g = -1;
    eot_at = 1'b0;
    eot_prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      urx = frame[i];
      idle(CPB);
    end
    urx = stop_bit;
    for (int c = 0; c < CPB; c++) begin
      v_prev = urx_valid;
      e_prev = eot;
      @(posedge clk);
      #1;
      if (lat_g < 0 && urx_valid && !v_prev) begin
        lat_g = c + 1;
        eot_at = eot;
        eot_prev = e_prev;
      end
    end
    urx = 1'b1;
`ifdef SVC_UART_RX_MON_EOT_EN
    if (stop_bit && b == 8'h04) eot_exp = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    urx = 1'b1;
    urx_ready = 1'b0;
    rand_ready_en = 1'b0;
    eot_exp = 1'b0;
    idle(5);
    tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", urx_valid); end
    tests++; if (urx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", urx_data); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (eot !== 1'b0) begin fails++; $display("FAIL reset_eot: got %b want 0", eot); end
    rst_n = 1'b1;
    idle(10);
    tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", urx_valid); end
  endtask

  task automatic test_basic();
    int lat0;
    clear_obs();
    urx_ready = 1'b1;
    send_byte(8'h55, 1'b1);
    lat0 = lat_g;
    send_byte(8'hA3, 1'b1);
    idle(20);
    // The byte appears about half a bit into the stop bit, plus synchronizer and edge-detect delay.
    tests++; if (lat0 < HALF - 2 || lat0 > HALF + 8) begin fails++; $display("FAIL basic_latency: got %0d cycles want %0d..%0d", lat0, HALF - 2, HALF + 8); end
    tests++; if (rx_q.size() !== 2) begin fails++; $display("FAIL basic_count: got %0d want 2", rx_q.size()); end
    else begin
      tests++; if (rx_q[0] !== 8'h55) begin fails++; $display("FAIL basic_byte0: got %h want 55", rx_q[0]); end
      tests++; if (rx_q[1] !== 8'hA3) begin fails++; $display("FAIL basic_byte1: got %h want a3", rx_q[1]); end
    end
    tests++; if (fe_cnt !== 0 || ov_cnt !== 0) begin fails++; $display("FAIL basic_pulses: got fe=%0d ov=%0d want 0/0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    clear_obs();
    urx_ready = 1'b1;
    urx = 1'b0;
    idle(50);
    urx = 1'b1;
    idle(300);
    tests++; if (rx_q.size() !== 0 || fe_cnt !== 0) begin fails++; $display("FAIL glitch_reject: got bytes=%0d fe=%0d want 0/0", rx_q.size(), fe_cnt); end
    send_byte(8'h7E, 1'b1);
    idle(20);
    tests++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h7E) begin fails++; $display("FAIL glitch_next: got n=%0d b=%h want 1/7e", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    urx_ready = 1'b1;
    send_byte(8'h41, 1'b0);
    urx = 1'b0;
    idle(500);
    urx = 1'b1;
    idle(300);
    tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL frame_err_count: got %0d want 1", fe_cnt); end
    tests++; if (rx_q.size() !== 0) begin fails++; $display("FAIL frame_err_drop: got %0d bytes want 0", rx_q.size()); end
    send_byte(8'h42, 1'b1);
    idle(20);
    tests++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h42) begin fails++; $display("FAIL frame_err_next: got n=%0d b=%h want 1/42", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    tests++; if (fe_cnt !== 1) begin fails++; $display("FAIL frame_err_once: got %0d want 1", fe_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    int bad;
    clear_obs();
    urx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1);
      exp_q.push_back(8'(i));
    end
    idle(5);
    tests++; if (ov_cnt !== 0) begin fails++; $display("FAIL overrun_at_full: got %0d want 0", ov_cnt); end
    tests++; if (urx_valid !== 1'b1 || urx_data !== 8'h01) begin fails++; $display("FAIL overrun_hold: got v=%b d=%h want 1/01", urx_valid, urx_data); end
    send_byte(8'h09, 1'b1);
    idle(5);
    tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL overrun_count: got %0d want 1", ov_cnt); end
    urx_ready = 1'b1;
    idle(20);
    bad = 0;
    if (rx_q.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[k]) if (rx_q[k] !== exp_q[k]) bad = 1;
    tests++; if (bad != 0) begin fails++; $display("FAIL overrun_drain: got %0d bytes (first %h) want 8 bytes 01..08", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL overrun_empty: got %b want 0", urx_valid); end
    tests++; if (eot !== eot_exp) begin fails++; $display("FAIL overrun_eot: got %b want %b", eot, eot_exp); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_obs();
    urx_ready = 1'b1;
    b = 8'hC3;
    urx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      urx = b[i];
      idle(CPB);
    end
    urx = b[4];
    idle(HALF);
    rst_n = 1'b0;
    urx = 1'b1;
    eot_exp = 1'b0;
    idle(5);
    tests++; if (urx_valid !== 1'b0 || eot !== 1'b0) begin fails++; $display("FAIL midreset_outputs: got v=%b eot=%b want 0/0", urx_valid, eot); end
    rst_n = 1'b1;
    idle(3 * CPB);
    send_byte(8'h3C, 1'b1);
    idle(20);
    tests++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C) begin fails++; $display("FAIL midreset_rx: got n=%0d b=%h want 1/3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    tests++; if (fe_cnt !== 0) begin fails++; $display("FAIL midreset_fe: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_eot();
    clear_obs();
    urx_ready = 1'b1;
    send_byte(8'h0A, 1'b1);
    tests++; if (eot !== 1'b0) begin fails++; $display("FAIL eot_early: got %b want 0", eot); end
    send_byte(8'h04, 1'b1);
    tests++; if (lat_g < 0) begin fails++; $display("FAIL eot_byte_seen: got no urx_valid want one"); end
    else begin
      tests++; if (eot_at !== eot_exp || eot_prev !== 1'b0) begin fails++; $display("FAIL eot_edge: got before=%b at=%b want 0/%b", eot_prev, eot_at, eot_exp); end
    end
    idle(300);
    tests++; if (eot !== eot_exp) begin fails++; $display("FAIL eot_sticky: got %b want %b", eot, eot_exp); end
    tests++; if (rx_q.size() !== 2 || rx_q[1] !== 8'h04) begin fails++; $display("FAIL eot_delivery: got n=%0d want 2 ending 04", rx_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int bad;
    clear_obs();
    rand_ready_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      exp_q.push_back(b);
      idle($urandom_range(0, 400));
    end
    rand_ready_en = 1'b0;
    urx_ready = 1'b1;
    idle(20);
    bad = 0;
    if (rx_q.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[k]) if (rx_q[k] !== exp_q[k]) bad = 1;
    tests++; if (bad != 0) begin fails++; $display("FAIL random_stream: got %0d bytes want %0d in order", rx_q.size(), exp_q.size()); end
    tests++; if (fe_cnt !== 0 || ov_cnt !== 0) begin fails++; $display("FAIL random_pulses: got fe=%0d ov=%0d want 0/0", fe_cnt, ov_cnt); end
    tests++; if (eot !== eot_exp) begin fails++; $display("FAIL random_eot: got %b want %b", eot, eot_exp); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    rand_ready_en = 1'b0;
    eot_exp = 1'b0;
    urx = 1'b1;
    urx_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_eot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svc_uart_rx_mon.md
SVC_UART_RX_MON -- requirements
Module: svc_uart_rx_mon

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_MHZ, default 25, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive byte buffer depth; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port urx  input  1  asynchronous serial line (8N1, LSB first, idle high); typically driven by the SoC uart_tx.
REQ-007 SHALL have port urx_valid  output  1  a received byte is at the FIFO head.
REQ-008 SHALL have port urx_data  output  8  FIFO head byte; valid only while urx_valid is high.
REQ-009 SHALL have port urx_ready  input  1  consumer accepts the head byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
REQ-012 SHALL have port eot  output  1  sticky flag for end-of-transmission, per REQ-030.

Function
REQ-013 SHALL define CLKS_PER_BIT = (CLOCK_FREQ_MHZ*1_000_000)/BAUD_RATE, integer division (217 at defaults), and HALF_BIT = CLKS_PER_BIT/2 (108).
REQ-014 SHALL pass urx through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value urx_s.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a bit-period counter and a 3-bit bit index.
REQ-016 IDLE: when urx_s==0, go to START and clear the counter.
REQ-017 START: after HALF_BIT clocks, sample urx_s; 0 -> DATA with the counter cleared; 1 -> IDLE (glitch rejected, no output).
REQ-018 DATA: every CLKS_PER_BIT clocks, shift urx_s into the byte LSB-first; after the 8th sample, go to STOP.
REQ-019 STOP: after CLKS_PER_BIT clocks, sample urx_s; 1 -> push the byte and go to IDLE; 0 -> pulse frame_err, discard the byte, go to BREAK.
REQ-020 BREAK: stay until urx_s==1, then go to IDLE; no start detection in BREAK.
REQ-021 The FIFO SHALL be show-ahead: urx_valid = not empty, and urx_data = head byte with no read latency.
REQ-022 A pushed byte SHALL appear on urx_valid/urx_data the cycle after the stop-bit sample when the FIFO was empty.
REQ-023 Pop SHALL occur on urx_valid && urx_ready; urx_data SHALL hold while urx_valid && !urx_ready.
REQ-024 Push while full with no pop in the same cycle: byte dropped, overrun pulses, FIFO unchanged.
REQ-025 Push while full with a pop in the same cycle: the push SHALL be accepted, with no overrun.
REQ-026 Push and pop in the same cycle when the FIFO holds 1 entry: the new byte becomes head next cycle and urx_valid stays high.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-028 urx_ready asserted while urx_valid is low SHALL have no effect.

Reset
REQ-029 While rst_n is low: state IDLE, counters 0, synchronizer 1, FIFO empty, urx_valid 0, urx_data 0, frame_err 0, overrun 0, eot 0; a frame in progress is abandoned, and after release a new start bit is needed.

Configuration
REQ-030 With macro SVC_UART_RX_MON_EOT_EN defined, a byte 0x04 pushed into the FIFO SHALL set eot the cycle after the push; eot stays set until reset; the byte is still delivered normally.
REQ-031 Without SVC_UART_RX_MON_EOT_EN, eot SHALL be tied to 0 and no compare logic SHALL be built.

Verification
REQ-032 Defaults, urx_ready=1, send 0x55 then 0xA3: urx_valid pulses twice with urx_data 0x55 then 0xA3, and frame_err/overrun stay 0.
REQ-033 urx low for 50 clocks then high: no urx_valid and no frame_err; a following 0x7E is received correctly.
REQ-034 Send 0x41 with stop bit 0, then hold the line low 500 clocks, then send 0x42: frame_err pulses once, no 0x41 is output, and 0x42 is received.
REQ-035 urx_ready=0, send 9 bytes 0x01..0x09: overrun pulses once at the 9th stop bit; then raise urx_ready and read 0x01..0x08 in order, after which urx_valid is 0.
REQ-036 Assert rst_n low during bit 4 of 0xC3, release, then send 0x3C: only 0x3C is output.
REQ-037 With SVC_UART_RX_MON_EOT_EN, send 0x0A, 0x04: eot rises one cycle after the 0x04 push and stays high; without the macro, eot stays 0.
